// File: rtl/cpu_sequencer.sv
// Multicycle control sequencer for the LEGv8 core.
// Ports:
//   clk_i        system clock, all state changes on the rising edge
//   reset_i      synchronous active-high reset
//   run_i        1 = execute, 0 = stop at the next instruction boundary
//   opcode_i     instruction[31:21], sampled in DECODE
//   alu_zero_i   ALU zero flag, used in EXECUTE for CBZ
//   mem_ready_i  data memory completion, used in MEM
//   ir_en_o, alu_en_o, mem_read_o, mem_write_o, reg_write_o,
//   pc_en_o, pc_src_o  one-cycle datapath strobes
//   busy_o       1 in any state except IDLE and TRAP
//   illegal_o    sticky unsupported-opcode flag
//   state_o      current state encoding
//   retired_o    retired-instruction count (wraps)
module cpu_sequencer #(
    parameter int RETIRE_W = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                run_i,
    input  logic [10:0]         opcode_i,
    input  logic                alu_zero_i,
    input  logic                mem_ready_i,
    output logic                ir_en_o,
    output logic                alu_en_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                reg_write_o,
    output logic                pc_en_o,
    output logic                pc_src_o,
    output logic                busy_o,
    output logic                illegal_o,
    output logic [2:0]          state_o,
    output logic [RETIRE_W-1:0] retired_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_TRAP    = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        C_NONE  = 3'd0,
        C_RTYPE = 3'd1,
        C_LDUR  = 3'd2,
        C_STUR  = 3'd3,
        C_CBZ   = 3'd4,
        C_B     = 3'd5
    } class_e;

    state_e              state_q, state_d;
    class_e              cls_q, cls_dec;
    logic                illegal_q;
    logic [RETIRE_W-1:0] retired_q;
    logic                retire;

    // Opcode classification; only meaningful while in DECODE.
    always_comb begin
        cls_dec = C_NONE;
        unique case (1'b1)
            opcode_i == 11'h7C2:        cls_dec = C_LDUR;
            opcode_i == 11'h7C0:        cls_dec = C_STUR;
            opcode_i == 11'h458,
            opcode_i == 11'h658,
            opcode_i == 11'h450,
            opcode_i == 11'h550:        cls_dec = C_RTYPE;
            opcode_i[10:3] == 8'hB4:    cls_dec = C_CBZ;
            opcode_i[10:5] == 6'b000101: cls_dec = C_B;
            default:                    cls_dec = C_NONE;
        endcase
    end

    // An instruction retires in exactly one of these cycles.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_EXECUTE: retire = (cls_q == C_B) || (cls_q == C_CBZ);
            S_MEM:     retire = (cls_q == C_STUR) && mem_ready_i;
            S_WB:      retire = 1'b1;
            default:   retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (run_i) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (cls_dec == C_NONE) state_d = S_TRAP;
                else                   state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                case (cls_q)
                    C_RTYPE:      state_d = S_WB;
                    C_LDUR,
                    C_STUR:       state_d = S_MEM;
                    C_CBZ, C_B:   state_d = run_i ? S_FETCH : S_IDLE;
                    default:      state_d = S_IDLE;
                endcase
            end
            S_MEM: begin
                if (mem_ready_i) begin
                    if (cls_q == C_LDUR) state_d = S_WB;
                    else state_d = run_i ? S_FETCH : S_IDLE;
                end
            end
            S_WB:    state_d = run_i ? S_FETCH : S_IDLE;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ir_en_o     = 1'b0;
        alu_en_o    = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        reg_write_o = 1'b0;
        pc_en_o     = 1'b0;
        pc_src_o    = 1'b0;
        case (state_q)
            S_FETCH: ir_en_o = 1'b1;
            S_EXECUTE: begin
                alu_en_o = 1'b1;
                if (cls_q == C_B) begin
                    pc_en_o  = 1'b1;
                    pc_src_o = 1'b1;
                end else if (cls_q == C_CBZ) begin
                    pc_en_o  = 1'b1;
                    pc_src_o = alu_zero_i;
                end
            end
            S_MEM: begin
                mem_read_o  = (cls_q == C_LDUR);
                mem_write_o = (cls_q == C_STUR);
                pc_en_o     = (cls_q == C_STUR) && mem_ready_i;
            end
            S_WB: begin
                reg_write_o = 1'b1;
                pc_en_o     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cls_q     <= C_NONE;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            if (state_q == S_DECODE) begin
                cls_q <= cls_dec;
                if (cls_dec == C_NONE) illegal_q <= 1'b1;
            end
            if (retire) retired_q <= retired_q + RETIRE_W'(1);
        end
    end

    assign busy_o    = (state_q != S_IDLE) && (state_q != S_TRAP);
    assign illegal_o = illegal_q;
    assign state_o   = state_q;
    assign retired_o = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer.
// Per-instruction phase schedules are built from class rules and compared each cycle.
module tb_cpu_sequencer;

    localparam int RW   = 6;
    localparam int WRAP = 1 << RW;

    logic          clk = 1'b0;
    logic          reset_i, run_i, alu_zero_i, mem_ready_i;
    logic [10:0]   opcode_i;
    logic          ir_en_o, alu_en_o, mem_read_o, mem_write_o;
    logic          reg_write_o, pc_en_o, pc_src_o, busy_o, illegal_o;
    logic [2:0]    state_o;
    logic [RW-1:0] retired_o;

    cpu_sequencer #(.RETIRE_W(RW)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .run_i       (run_i),
        .opcode_i    (opcode_i),
        .alu_zero_i  (alu_zero_i),
        .mem_ready_i (mem_ready_i),
        .ir_en_o     (ir_en_o),
        .alu_en_o    (alu_en_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .reg_write_o (reg_write_o),
        .pc_en_o     (pc_en_o),
        .pc_src_o    (pc_src_o),
        .busy_o      (busy_o),
        .illegal_o   (illegal_o),
        .state_o     (state_o),
        .retired_o   (retired_o)
    );

    always #5 clk = ~clk;

    // sv = {ir, alu, mrd, mwr, rwr, pc_en, pc_src, busy}
    typedef struct {
        logic [2:0] st;
        logic [7:0] sv;
        bit run, mrdy, rst, ret, trap, chk;
    } step_t;

    step_t  plan[$];
    step_t  e;
    bit     chk_en = 1'b0;
    int     n_chk = 0, n_fail = 0;
    int     m_ret = 0;
    bit     m_ill = 1'b0;
    int     n_mr = 0, n_rw = 0;
    logic [10:0] cur_op = 11'h0;
    bit     cur_z = 1'b0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction class: 0 illegal, 1 R-type, 2 LDUR, 3 STUR, 4 CBZ, 5 B
    function automatic int classify(input logic [10:0] op);
        logic [7:0] hi8;
        logic [5:0] hi6;
        hi8 = op[10:3];
        hi6 = op[10:5];
        if (op == 11'h7C2) return 2;
        if (op == 11'h7C0) return 3;
        if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550)
            return 1;
        if (hi8 == 8'hB4) return 4;
        if (hi6 == 6'b000101) return 5;
        return 0;
    endfunction

    function automatic step_t mk(input logic [2:0] st, input logic [6:0] strb,
                                 input bit run);
        step_t s;
        s.st   = st;
        s.sv   = {strb, (st != 3'd0) && (st != 3'd7)};
        s.run  = run;
        s.mrdy = 1'b1;
        s.rst  = 1'b0;
        s.ret  = 1'b0;
        s.trap = 1'b0;
        s.chk  = 1'b1;
        return s;
    endfunction

    task automatic build(input logic [10:0] op, input bit z, input int stalls,
                         input bit keep);
        int    k;
        step_t s;
        k = classify(op);
        plan.delete();
        plan.push_back(mk(3'd1, 7'b1000000, 1'b1));
        s = mk(3'd2, 7'b0, keep);
        s.trap = (k == 0);
        plan.push_back(s);
        if (k == 0) begin
            for (int i = 0; i < 10; i++) begin
                s = mk(3'd7, 7'b0, 1'b1);
                s.mrdy = i[0];
                plan.push_back(s);
            end
            return;
        end
        s = mk(3'd3, {1'b0, 1'b1, 3'b0, k >= 4, (k == 5) || (k == 4 && z)}, keep);
        s.ret = (k >= 4);
        plan.push_back(s);
        if (k == 2 || k == 3) begin
            for (int i = 0; i < stalls; i++) begin
                s = mk(3'd4, {2'b0, k == 2, k == 3, 3'b0}, keep);
                s.mrdy = 1'b0;
                plan.push_back(s);
            end
            s = mk(3'd4, {2'b0, k == 2, k == 3, 1'b0, k == 3, 1'b0}, keep);
            s.ret = (k == 3);
            plan.push_back(s);
        end
        if (k == 1 || k == 2) begin
            s = mk(3'd5, 7'b0000110, keep);
            s.ret = 1'b1;
            plan.push_back(s);
        end
    endtask

    task automatic cyc(input step_t s);
        run_i       = s.run;
        reset_i     = s.rst;
        mem_ready_i = s.mrdy;
        opcode_i    = cur_op;
        alu_zero_i  = cur_z;
        e           = s;
        chk_en      = s.chk;
        @(posedge clk);
        #1;
        if (s.rst) begin
            m_ret = 0;
            m_ill = 1'b0;
        end else begin
            if (s.ret) m_ret = (m_ret + 1) % WRAP;
            if (s.trap) m_ill = 1'b1;
        end
    endtask

    task automatic play(input logic [10:0] op, input bit z, input int abort_at);
        step_t s;
        cur_op = op;
        cur_z  = z;
        for (int i = 0; i < plan.size(); i++) begin
            s = plan[i];
            if (i == abort_at) begin
                s.rst = 1'b1;
                cyc(s);
                return;
            end
            cyc(s);
        end
    endtask

    task automatic instr(input logic [10:0] op, input bit z, input int stalls,
                         input bit keep);
        build(op, z, stalls, keep);
        play(op, z, -1);
    endtask

    task automatic idle(input bit run, input bit rst);
        step_t s;
        s = mk(3'd0, 7'b0, run);
        s.rst = rst;
        cyc(s);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("state", 32'(state_o), 32'(e.st));
            check("strobes", 32'({ir_en_o, alu_en_o, mem_read_o, mem_write_o,
                                  reg_write_o, pc_en_o, pc_src_o, busy_o}),
                  32'(e.sv));
            check("illegal", 32'(illegal_o), 32'(m_ill));
            check("retired", 32'(retired_o), 32'(m_ret));
            if (mem_read_o)  n_mr++;
            if (reg_write_o) n_rw++;
        end
    end

    initial begin
        step_t s;
        int    mr0, rw0;
        reset_i = 1'b1; run_i = 1'b0; opcode_i = 11'h0;
        alu_zero_i = 1'b0; mem_ready_i = 1'b1;
        s = mk(3'd0, 7'b0, 1'b0);
        s.rst = 1'b1;
        s.chk = 1'b0;
        cyc(s);
        cyc(s);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);

        build(11'h458, 1'b0, 0, 1'b1);
        check("len_add", plan.size(), 4);
        play(11'h458, 1'b0, -1);
        check("ret_after_add", 32'(retired_o), 1);

        build(11'h7C2, 1'b0, 2, 1'b1);
        check("len_ldur", plan.size(), 7);
        mr0 = n_mr;
        play(11'h7C2, 1'b0, -1);
        check("ldur_mrd_cycles", n_mr - mr0, 3);

        build(11'h7C0, 1'b0, 0, 1'b1);
        check("len_stur", plan.size(), 4);
        rw0 = n_rw;
        play(11'h7C0, 1'b0, -1);
        check("stur_no_rwr", n_rw - rw0, 0);

        build(11'h5A0, 1'b1, 0, 1'b1);
        check("len_cbz", plan.size(), 3);
        play(11'h5A0, 1'b1, -1);
        instr(11'h5A0, 1'b0, 0, 1'b1);
        instr(11'h658, 1'b1, 0, 1'b1);
        instr(11'h450, 1'b0, 0, 1'b1);
        instr(11'h550, 1'b0, 0, 1'b1);
        instr(11'h7C0, 1'b0, 3, 1'b1);

        build(11'h0A0, 1'b0, 0, 1'b0);
        check("len_b", plan.size(), 3);
        play(11'h0A0, 1'b0, -1);
        idle(1'b0, 1'b0);
        check("busy_after_stop", 32'(busy_o), 0);
        idle(1'b0, 1'b0);

        idle(1'b1, 1'b0);
        instr(11'h000, 1'b0, 0, 1'b1);
        check("trap_flag", 32'(illegal_o), 1);
        s = mk(3'd7, 7'b0, 1'b1);
        s.rst = 1'b1;
        cyc(s);
        idle(1'b0, 1'b0);
        check("ill_cleared", 32'(illegal_o), 0);

        idle(1'b1, 1'b0);
        while (m_ret != WRAP - 1) instr(11'h0A0, 1'b0, 0, 1'b1);
        instr(11'h0A1, 1'b0, 0, 1'b0);
        check("retired_wrap", 32'(retired_o), 0);
        idle(1'b0, 1'b0);

        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);
        build(11'h7C2, 1'b0, 5, 1'b1);
        play(11'h7C2, 1'b0, 4);
        idle(1'b0, 1'b0);
        check("mrd_after_abort", 32'(mem_read_o), 0);
        idle(1'b1, 1'b0);
        instr(11'h458, 1'b0, 0, 1'b0);
        idle(1'b0, 1'b0);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multicycle control sequencer for the LEGv8 core: steps the fetch/decode datapath (iFetch, iDecode) and the downstream ALU and data memory through per-instruction phases. Latches the decoded opcode class, then issues one-cycle enables for IR load, register write, memory access and PC update. Counts retired instructions and traps unsupported opcodes. Sits beside the datapath top level and replaces the free-running single-cycle PC update.

## Interface
- RETIRE_W, 16: width of retired-instruction counter
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk
- run  in  1  level; 1 = execute instructions, 0 = stop at next instruction boundary
- opcode  in  11  instruction[31:21] from iDecode, valid in DECODE
- alu_zero  in  1  ALU zero flag, valid in EXECUTE
- mem_ready  in  1  data memory completion, valid in MEM
- ir_en  out  1  load instruction register
- alu_en  out  1  ALU operands/result capture
- mem_read  out  1  data memory read strobe
- mem_write  out  1  data memory write strobe
- reg_write  out  1  register file write enable
- pc_en  out  1  PC update enable
- pc_src  out  1  0 = PC+4, 1 = branch_target
- busy  out  1  1 in any state except IDLE and TRAP
- illegal  out  1  sticky unsupported-opcode flag
- state  out  3  current state encoding (debug)
- retired  out  RETIRE_W  retired-instruction count

## Operation
- States (encoding): IDLE 0, FETCH 1, DECODE 2, EXECUTE 3, MEM 4, WB 5, TRAP 7.
- Opcode classes latched at end of DECODE: LDUR 11'h7C2, STUR 11'h7C0, ADD 11'h458, SUB 11'h658, AND 11'h450, ORR 11'h550 (R-type), CBZ opcode[10:3]=8'hB4, B opcode[10:5]=6'b000101; anything else illegal.
- IDLE: all strobes 0; run=1 -> FETCH.
- FETCH: ir_en=1 -> DECODE.
- DECODE: no strobes; legal -> EXECUTE; illegal -> TRAP (illegal set same edge).
- EXECUTE: alu_en=1. R-type/LDUR -> next per class (R-type -> WB, LDUR/STUR -> MEM). B: pc_en=1, pc_src=1, retire. CBZ: pc_en=1, pc_src=alu_zero, retire.
- MEM: LDUR mem_read=1, STUR mem_write=1, held while mem_ready=0 (no timeout). On mem_ready=1: LDUR -> WB; STUR pc_en=1, pc_src=0, retire.
- WB: reg_write=1, pc_en=1, pc_src=0, retire.
- Retire: retired increments by 1 (wraps 2^RETIRE_W-1 -> 0); next state FETCH if run=1 else IDLE.
- run=0 mid-instruction: current instruction completes; stop only at retire.
- TRAP: all strobes 0, busy=0, illegal=1; exit only by reset.
- Outputs decode combinationally from state, latched class, alu_zero and mem_ready; pc_src=0 whenever pc_en=0.

## Timing
- Reset: state=IDLE, class cleared, illegal=0, retired=0; all strobes, busy=0 in the cycle after reset edge. Reset mid-instruction aborts with no further strobes.
- Cycles per instruction (FETCH to retire inclusive, mem_ready=1 first MEM cycle): R-type 4, LDUR 5, STUR 4, CBZ 3, B 3. Each mem_ready=0 cycle adds 1.
- Back-to-back with run=1: FETCH of next instruction in cycle after retire.
- Exactly one of ir_en, mem_read, mem_write, reg_write pulses per cycle at most; pc_en exactly once per instruction.
- reset and run=1 same edge: reset wins, state IDLE.
- retired updates on retire edge; visible next cycle.

## Test plan
- Reset, run=1, opcode=11'h458 (ADD) -> states 1,2,3,5,1; reg_write=1 in WB only; pc_en=1,pc_src=0 in WB; retired=1.
- LDUR 11'h7C2 with mem_ready low 2 cycles -> mem_read high 3 cycles, then WB reg_write=1; 7 cycles FETCH-to-retire.
- STUR 11'h7C0 -> mem_write=1 one cycle, reg_write never asserted, pc_en in MEM; CBZ 11'h5A0 with alu_zero=1 -> pc_src=1 in EXECUTE; alu_zero=0 -> pc_src=0.
- B 11'h0A0 -> pc_en=1,pc_src=1 at cycle 3; run dropped during DECODE -> instruction retires, then IDLE, busy=0.
- opcode 11'h000 -> TRAP after DECODE, illegal=1, no strobes thereafter for 10 cycles; reset -> illegal=0, IDLE.
- Force retired to 16'hFFFF via 65535 B instructions (or preload in sim) -> next retire gives 0; reset asserted in MEM with mem_ready=0 -> mem_read low next cycle, state IDLE.
